// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and
// grant owner IDs.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/rv_mem_arbiter_prio.sv
// Fetch/data priority select: data wins by default, fetch is forced through
// after STARVE_LIMIT consecutive data wins over a pending fetch.
module rv_arb_prio
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_if_valid,
    input  logic i_d_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          w_starved;
    logic          w_both;

    assign w_both    = i_if_valid & i_d_valid;
    assign w_starved = (r_starve_cnt >= CW'(STARVE_LIMIT));
    assign grant_if  = i_en & i_if_valid & (~i_d_valid | w_starved);
    assign grant_d   = i_en & i_d_valid & ~(i_if_valid & w_starved);

    // Only a contested data win counts toward starvation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (grant_if) begin
            r_starve_cnt <= '0;
        end else if (grant_d && w_both) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding at a time, with a response timeout.
//   state | meaning
//   IDLE  | no transaction; requests accepted, responses delivered here
//   ISSUE | m_req_valid held with latched request until m_req_ready
//   WAIT  | awaiting m_rsp_valid, timeout counter running
module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_req_addr,
    output logic            if_rsp_valid,
    output logic [31:0]     if_rsp_data,
    output logic            if_rsp_err,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW-1:0]   d_req_addr,
    input  logic            d_req_we,
    input  logic [DW-1:0]   d_req_wdata,
    input  logic [DW/8-1:0] d_req_wstrb,
    output logic            d_rsp_valid,
    output logic [DW-1:0]   d_rsp_rdata,
    output logic            d_rsp_err,
    output logic            m_req_valid,
    input  logic            m_req_ready,
    output logic [AW-1:0]   m_req_addr,
    output logic            m_req_we,
    output logic [DW-1:0]   m_req_wdata,
    output logic [DW/8-1:0] m_req_wstrb,
    input  logic            m_rsp_valid,
    input  logic [DW-1:0]   m_rsp_rdata,
    output logic            busy,
    output logic            grant_id
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_accept;
    logic              w_tmo_hit;
    logic              w_done;
    logic [31:0]       w_fetch_word;
    logic [AW-1:0]     r_addr;
    logic              r_we;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wstrb;
    logic              r_gnt;
    logic [TW-1:0]     r_tmo;
    logic              r_if_rsp_valid;
    logic [31:0]       r_if_rsp_data;
    logic              r_if_rsp_err;
    logic              r_d_rsp_valid;
    logic [DW-1:0]     r_d_rsp_rdata;
    logic              r_d_rsp_err;

    rv_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (r_state == ST_IDLE),
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
        .grant_if   (w_grant_if),
        .grant_d    (w_grant_d)
    );

    assign w_accept     = w_grant_if | w_grant_d;
    // Leaving at TIMEOUT-1 means the counter reaches TIMEOUT on the exit edge.
    assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));
    assign w_done       = (r_state == ST_WAIT) && (m_rsp_valid || w_tmo_hit);
    assign w_fetch_word = r_addr[2] ? m_rsp_rdata[63:32] : m_rsp_rdata[31:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_req_valid  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                m_req_valid = 1'b1;
                if (m_req_ready) w_next_state = ST_WAIT;
            end
            ST_WAIT:  if (w_done) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_gnt          <= GNT_IF;
            r_tmo          <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_if_rsp_err   <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_d_rsp_rdata  <= '0;
            r_d_rsp_err    <= 1'b0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            if (r_state == ST_IDLE && w_accept) begin
                r_gnt   <= w_grant_d ? GNT_D : GNT_IF;
                r_addr  <= w_grant_d ? d_req_addr : if_req_addr;
                r_we    <= w_grant_d & d_req_we;
                r_wdata <= w_grant_d ? d_req_wdata : '0;
                r_wstrb <= w_grant_d ? d_req_wstrb : '0;
            end
            if (r_state == ST_ISSUE && m_req_ready) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo <= r_tmo + 1'b1;
            end
            // A response arriving on the timeout cycle still counts as success.
            if (w_done) begin
                if (r_gnt == GNT_D) begin
                    r_d_rsp_valid <= 1'b1;
                    r_d_rsp_rdata <= (m_rsp_valid && !r_we) ? m_rsp_rdata : '0;
                    r_d_rsp_err   <= ~m_rsp_valid;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= m_rsp_valid ? w_fetch_word : 32'h0;
                    r_if_rsp_err   <= ~m_rsp_valid;
                end
            end
        end
    end

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;
    assign if_rsp_err   = r_if_rsp_err;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rsp_rdata  = r_d_rsp_rdata;
    assign d_rsp_err    = r_d_rsp_err;
    assign m_req_addr   = r_addr;
    assign m_req_we     = r_we;
    assign m_req_wdata  = r_wdata;
    assign m_req_wstrb  = r_wstrb;
    assign busy         = (r_state != ST_IDLE);
    assign grant_id     = r_gnt;

endmodule
